// File: rtl/rr_arb8.sv
// Eight-way round-robin arbiter with a bounded hold time per grant.
// Grant, index and valid are registered; a release or timeout re-arbitrates in the same edge.
module rr_arb8 #(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       EN,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       gnt_valid
);

    localparam int unsigned HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t        state, state_n;
    logic [2:0]    ptr, ptr_n;
    logic [HW-1:0] hold_cnt, hold_n;
    logic [7:0]    gnt_n;
    logic [2:0]    id_n;
    logic          valid_n;
    logic          load;
    logic          clear;
    logic [2:0]    base;
    logic [2:0]    win;
    logic          found;

    // In GRANT the search starts just past the owner, which is where ptr would move on release.
    always_comb begin
        base  = (state == GRANT) ? 3'(gnt_id + 3'd1) : ptr;
        found = 1'b0;
        win   = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (!found && req[3'(base + 3'(i))]) begin
                found = 1'b1;
                win   = 3'(base + 3'(i));
            end
        end
    end

    // State register, pointer, hold counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 3'd0;
            hold_cnt  <= '0;
            gnt       <= 8'd0;
            gnt_id    <= 3'd0;
            gnt_valid <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            hold_cnt  <= hold_n;
            gnt       <= gnt_n;
            gnt_id    <= id_n;
            gnt_valid <= valid_n;
        end
    end

    // Next-state logic: keep, hand over, or drop the grant.
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        hold_n  = hold_cnt;
        load    = 1'b0;
        clear   = 1'b0;
        case (state)
            IDLE: begin
                hold_n = '0;
                if (EN && found) begin
                    state_n = GRANT;
                    load    = 1'b1;
                    hold_n  = HW'(1);
                end
            end
            GRANT: begin
                if (!EN) begin
                    state_n = IDLE;
                    ptr_n   = 3'(gnt_id + 3'd1);
                    hold_n  = '0;
                    clear   = 1'b1;
                end else if (req[gnt_id] && (hold_cnt < HOLD_MAX)) begin
                    hold_n = HW'(hold_cnt + HW'(1));
                end else begin
                    ptr_n = 3'(gnt_id + 3'd1);
                    if (found) begin
                        load   = 1'b1;
                        hold_n = HW'(1);
                    end else begin
                        state_n = IDLE;
                        hold_n  = '0;
                        clear   = 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                clear   = 1'b1;
            end
        endcase
    end

    // Output logic: next values for the registered grant outputs.
    always_comb begin
        gnt_n   = gnt;
        id_n    = gnt_id;
        valid_n = gnt_valid;
        if (load) begin
            gnt_n   = 8'(8'd1 << win);
            id_n    = win;
            valid_n = 1'b1;
        end else if (clear) begin
            gnt_n   = 8'd0;
            id_n    = 3'd0;
            valid_n = 1'b0;
        end
    end

endmodule
